// File: rtl/max_select_accumulator.sv
// max_select_accumulator: three-stage pipeline that picks the max (mode=0) or min (mode=1) of
// CH packed signed channels per accepted beat and adds it into a saturating frame accumulator.
// After LEN accumulated samples the frame sum is published on result/sat with a done pulse.
//
// Ports:
//   clock    - sole clock, rising edge
//   reset    - asynchronous active-high reset
//   in_valid - in_data/mode hold a sample this cycle
//   in_data  - CH packed signed N-bit channels, channel i at [i*N +: N]
//   mode     - 0 = select max channel, 1 = select min channel
//   clear    - synchronous frame abort (flushes pipeline, keeps result/sat)
//   result   - signed saturated sum of the last completed frame
//   done     - one-cycle pulse when result/sat update
//   sat      - last completed frame clamped at least once
//   count    - samples accumulated in the current frame (0..LEN-1)
module max_select_accumulator #(
   parameter int unsigned N     = 4,
   parameter int unsigned CH    = 4,
   parameter int unsigned ACC_W = 20,
   parameter int unsigned LEN   = 8
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         in_valid,
   input  logic [CH*N-1:0]              in_data,
   input  logic                         mode,
   input  logic                         clear,
   output logic [ACC_W-1:0]             result,
   output logic                         done,
   output logic                         sat,
   output logic [$clog2(LEN+1)-1:0]     count
);

   localparam int unsigned CW = $clog2(LEN + 1);
   localparam logic [ACC_W-1:0] AccMax = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] AccMin = {1'b1, {(ACC_W-1){1'b0}}};

   // Stage 1: captured beat
   logic              s1_valid_q, s1_valid_d;
   logic [CH*N-1:0]   s1_data_q, s1_data_d;
   logic              s1_mode_q, s1_mode_d;
   // Stage 2: selected channel value
   logic              s2_valid_q, s2_valid_d;
   logic [N-1:0]      s2_val_q, s2_val_d;
   // Stage 3: frame accumulator and published result
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [CW-1:0]     count_q, count_d;
   logic              ovf_q, ovf_d;
   logic [ACC_W-1:0]  result_q, result_d;
   logic              sat_q, sat_d;
   logic              done_q, done_d;

   logic signed [N-1:0] best;
   logic signed [N-1:0] cand;
   logic [ACC_W:0]      sum_ext;
   logic                clamp;
   logic [ACC_W-1:0]    sat_sum;
   logic                last;

   always_comb begin
      s1_valid_d = in_valid & ~clear;
      s1_data_d  = in_valid ? in_data : s1_data_q;
      s1_mode_d  = in_valid ? mode : s1_mode_q;
   end

   // Strict compare keeps the earliest channel on ties.
   always_comb begin
      best = $signed(s1_data_q[N-1:0]);
      cand = best;
      for (int i = 1; i < int'(CH); i++) begin
         cand = $signed(s1_data_q[i*N +: N]);
         if (s1_mode_q ? (cand < best) : (cand > best)) begin
            best = cand;
         end
      end
      s2_valid_d = s1_valid_q & ~clear;
      s2_val_d   = s1_valid_q ? best : s2_val_q;
   end

   // One extra bit of headroom; overflow shows as disagreement of the top two bits.
   always_comb begin
      sum_ext = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-N){s2_val_q[N-1]}}, s2_val_q};
      clamp   = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
      if (clamp) begin
         sat_sum = sum_ext[ACC_W] ? AccMin : AccMax;
      end else begin
         sat_sum = sum_ext[ACC_W-1:0];
      end
      last = (count_q == CW'(LEN - 1));
   end

   always_comb begin
      acc_d    = acc_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      result_d = result_q;
      sat_d    = sat_q;
      done_d   = 1'b0;
      if (clear) begin
         acc_d   = '0;
         count_d = '0;
         ovf_d   = 1'b0;
      end else if (s2_valid_q) begin
         if (last) begin
            result_d = sat_sum;
            sat_d    = ovf_q | clamp;
            done_d   = 1'b1;
            acc_d    = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
         end else begin
            acc_d   = sat_sum;
            count_d = count_q + CW'(1);
            ovf_d   = ovf_q | clamp;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         s1_mode_q  <= 1'b0;
         s2_valid_q <= 1'b0;
         s2_val_q   <= '0;
         acc_q      <= '0;
         count_q    <= '0;
         ovf_q      <= 1'b0;
         result_q   <= '0;
         sat_q      <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_data_q  <= s1_data_d;
         s1_mode_q  <= s1_mode_d;
         s2_valid_q <= s2_valid_d;
         s2_val_q   <= s2_val_d;
         acc_q      <= acc_d;
         count_q    <= count_d;
         ovf_q      <= ovf_d;
         result_q   <= result_d;
         sat_q      <= sat_d;
         done_q     <= done_d;
      end
   end

   assign result = result_q;
   assign sat    = sat_q;
   assign done   = done_q;
   assign count  = count_q;

endmodule

// File: doc/max_select_accumulator.md
MAX_SELECT_ACCUMULATOR -- requirements
Module: max_select_accumulator

Interface
REQ-001 SHALL have parameter N, default 4: signed width of each channel sample.
REQ-002 SHALL have parameter CH, default 4: channels per input beat, CH >= 2.
REQ-003 SHALL have parameter ACC_W, default 20: signed accumulator/result width, ACC_W >= N+1.
REQ-004 SHALL have parameter LEN, default 8: accepted samples per frame, LEN >= 1.
REQ-005 SHALL have port clock  input  1  sole clock; all state changes on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port in_valid  input  1  in_data holds a sample this cycle.
REQ-008 SHALL have port in_data  input  CH*N  packed signed channels; channel i at bits [i*N+N-1 : i*N].
REQ-009 SHALL have port mode  input  1  0 = select maximum channel, 1 = select minimum; sampled with in_data.
REQ-010 SHALL have port clear  input  1  synchronous frame abort.
REQ-011 SHALL have port result  output  ACC_W  signed sum of last completed frame.
REQ-012 SHALL have port done  output  1  one-cycle pulse when result is updated.
REQ-013 SHALL have port sat  output  1  last completed frame saturated.
REQ-014 SHALL have port count  output  clog2(LEN+1)  samples accumulated in current frame.

Function
REQ-015 SHALL register in_data, mode, in_valid at stage 1 when in_valid=1; stage-1 valid SHALL be 0 otherwise.
REQ-016 SHALL compute at stage 2 the max (mode=0) or min (mode=1) of the CH signed stage-1 channels, registered with its valid.
REQ-017 SHALL resolve ties to lowest channel index; value is unaffected.
REQ-018 SHALL add the sign-extended stage-2 value into the accumulator at stage 3 when stage-2 valid=1; cycles without valid leave accumulator and count unchanged.
REQ-019 SHALL give fixed latency: sample accepted at edge k is in the accumulator after edge k+2; pipeline accepts one sample per cycle with no backpressure.
REQ-020 SHALL saturate the accumulator at +(2^(ACC_W-1)-1) and -2^(ACC_W-1); no wrap-around; set a frame-sticky overflow flag on any clamp.
REQ-021 SHALL, on the edge accumulating the LEN-th sample: load result with the saturated final sum, load sat with the sticky flag (including this add), pulse done for exactly the following cycle, and zero accumulator, count and sticky flag.
REQ-022 SHALL hold result and sat stable between done pulses.
REQ-023 SHALL, with clear=1 at an edge: zero accumulator, count, sticky flag, all stage valids; discard in_valid that cycle; leave result and sat unchanged; no done.
REQ-024 SHALL give clear priority over any concurrent completion (no done on that edge).
REQ-025 SHALL accept mode changes per sample; each sample uses its own captured mode.
REQ-026 SHALL treat count as 0..LEN-1 between frames; count never equals LEN at an output.

Reset
REQ-027 SHALL on reset=1, immediately and independent of clock, force result=0, done=0, sat=0, count=0, accumulator=0, all stage valids=0.
REQ-028 SHALL discard a partially accumulated frame or in-flight samples when reset asserts mid-frame.
REQ-029 SHALL accept the first sample at the first rising edge after reset deasserts.

Verification (N=4, CH=4, LEN=3 unless stated)
REQ-030 SHALL cover: reset asserted mid-frame between edges -> all outputs 0 at once; next frame sums only post-reset samples.
REQ-031 SHALL cover: ACC_W=8, mode=0, back-to-back {-5,3,7,-8},{2,2,-1,0},{-3,-4,-2,-6} -> result=7, sat=0, done one cycle, 3 edges after last sample.
REQ-032 SHALL cover: same data, mode=1 -> result=-15, sat=0.
REQ-033 SHALL cover: ACC_W=5, mode=0, three beats {7,0,0,0} -> result=15, sat=1; next frame {1,0,0,0}x3 -> result=3, sat=0.
REQ-034 SHALL cover: ACC_W=8, mode=0, maxes 4,5,6 with 2 idle cycles between beats -> result=15; done only after third valid beat.
REQ-035 SHALL cover: clear after 2 beats (maxes 7,7), then 3 beats maxes 1,2,3 -> result=6; no done at clear; earlier result retained until then.
